// File: rtl/gsim_pkg.sv
// Shared state type, stencil constants and saturation helper for the
// banded Gauss-Seidel solver.
package gsim_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCalc,
        StCheck,
        StOut
    } state_t;

    localparam int C1     = 13;
    localparam int C2     = 6;
    localparam int C3     = 1;
    localparam int RECIP  = 13107;
    localparam int RSHIFT = 18;
    localparam int SAT_W  = 128;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/gsim_row_pe.sv
// Combinational row evaluator: one Gauss-Seidel row update plus the
// magnitude of its change, saturated to the x width.
module gsim_row_pe
    import gsim_pkg::*;
#(
    parameter int unsigned B_W    = 16,
    parameter int unsigned X_W    = 32,
    parameter int unsigned X_FRAC = 16
) (
    input  logic signed [B_W-1:0] i_b,
    input  logic signed [X_W-1:0] i_xl1,
    input  logic signed [X_W-1:0] i_xl2,
    input  logic signed [X_W-1:0] i_xl3,
    input  logic signed [X_W-1:0] i_xr1,
    input  logic signed [X_W-1:0] i_xr2,
    input  logic signed [X_W-1:0] i_xr3,
    input  logic signed [X_W-1:0] i_x_old,
    output logic signed [X_W-1:0] o_x_new,
    output logic        [X_W-1:0] o_delta
);

    localparam int unsigned AW = X_W + 6;
    localparam int unsigned PW = AW + 16;

    logic signed [AW-1:0] w_b_ext;
    logic signed [AW-1:0] w_s1;
    logic signed [AW-1:0] w_s2;
    logic signed [AW-1:0] w_s3;
    logic signed [AW-1:0] w_acc;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_q;
    logic signed [X_W:0]  w_diff;
    logic        [X_W:0]  w_abs;

    assign w_b_ext = AW'(i_b) <<< X_FRAC;
    assign w_s1    = AW'(i_xl1) + AW'(i_xr1);
    assign w_s2    = AW'(i_xl2) + AW'(i_xr2);
    assign w_s3    = AW'(i_xl3) + AW'(i_xr3);
    assign w_acc   = w_b_ext + AW'(C1) * w_s1 - AW'(C2) * w_s2 + AW'(C3) * w_s3;

    // 13107 / 2^18 approximates 1/20; arithmetic shift gives floor.
    assign w_prod  = PW'(w_acc) * PW'(RECIP);
    assign w_q     = w_prod >>> RSHIFT;
    assign o_x_new = X_W'(sat_signed(SAT_W'(w_q), X_W));

    assign w_diff  = (X_W+1)'(o_x_new) - (X_W+1)'(i_x_old);
    assign w_abs   = w_diff[X_W] ? (X_W+1)'(-w_diff) : (X_W+1)'(w_diff);
    assign o_delta = w_abs[X_W] ? '1 : w_abs[X_W-1:0];

endmodule

// File: rtl/gsim_solver.sv
// Streaming Gauss-Seidel solver for the 7-point banded system: loads b,
// sweeps rows in place until converged or out of iterations, streams x out.
module gsim_solver
    import gsim_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned B_W    = 16,
    parameter int unsigned X_W    = 32,
    parameter int unsigned X_FRAC = 16,
    parameter int unsigned IT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic signed [B_W-1:0]  i_b_in,
    input  logic [IT_W-1:0]        i_iter_max,
    input  logic [X_W-1:0]         i_eps,
    input  logic                   i_early_en,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic signed [X_W-1:0]  o_x_out,
    output logic [$clog2(N)-1:0]   o_out_idx,
    output logic [IT_W-1:0]        o_iter_used,
    output logic                   o_converged,
    output logic                   o_busy
);

    localparam int unsigned IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [IW-1:0]         r_idx;
    logic signed [B_W-1:0] r_b [N];
    logic signed [X_W-1:0] r_x [N];
    logic [IT_W-1:0]       r_iter;
    logic [IT_W-1:0]       r_iter_max;
    logic [X_W-1:0]        r_eps;
    logic [X_W-1:0]        r_dmax;
    logic                  r_early;
    logic                  r_conv;
    logic                  r_alive;

    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_idx_last;
    logic                  w_done_early;
    logic                  w_done_limit;
    logic [IT_W-1:0]       w_iter_inc;
    logic [IT_W-1:0]       w_iter_eff;
    logic signed [X_W-1:0] w_xl1, w_xl2, w_xl3, w_xr1, w_xr2, w_xr3;
    logic signed [X_W-1:0] w_x_new;
    logic [X_W-1:0]        w_delta;

    // r_alive keeps in_ready low while reset is held.
    assign o_in_ready   = r_alive && (r_state == StIdle || r_state == StLoad);
    assign o_out_valid  = (r_state == StOut);
    assign o_x_out      = o_out_valid ? r_x[r_idx] : '0;
    assign o_out_idx    = o_out_valid ? r_idx : '0;
    assign o_iter_used  = r_iter;
    assign o_converged  = r_conv;
    assign o_busy       = (r_state != StIdle);

    assign w_in_hs      = i_in_valid && o_in_ready;
    assign w_out_hs     = o_out_valid && i_out_ready;
    assign w_idx_last   = (r_idx == LAST);
    assign w_iter_inc   = r_iter + IT_W'(1);
    assign w_iter_eff   = (r_iter_max == '0) ? IT_W'(1) : r_iter_max;
    assign w_done_early = r_early && (r_dmax <= r_eps);
    assign w_done_limit = (w_iter_inc == w_iter_eff);

    // Out-of-range neighbours read as zero.
    always_comb begin
        w_xl1 = '0;
        w_xl2 = '0;
        w_xl3 = '0;
        w_xr1 = '0;
        w_xr2 = '0;
        w_xr3 = '0;
        if (r_idx >= IW'(1)) w_xl1 = r_x[r_idx - IW'(1)];
        if (r_idx >= IW'(2)) w_xl2 = r_x[r_idx - IW'(2)];
        if (r_idx >= IW'(3)) w_xl3 = r_x[r_idx - IW'(3)];
        if (r_idx < IW'(N - 1)) w_xr1 = r_x[r_idx + IW'(1)];
        if (r_idx < IW'(N - 2)) w_xr2 = r_x[r_idx + IW'(2)];
        if (r_idx < IW'(N - 3)) w_xr3 = r_x[r_idx + IW'(3)];
    end

    gsim_row_pe #(
        .B_W    (B_W),
        .X_W    (X_W),
        .X_FRAC (X_FRAC)
    ) u_row_pe (
        .i_b     (r_b[r_idx]),
        .i_xl1   (w_xl1),
        .i_xl2   (w_xl2),
        .i_xl3   (w_xl3),
        .i_xr1   (w_xr1),
        .i_xr2   (w_xr2),
        .i_xr3   (w_xr3),
        .i_x_old (r_x[r_idx]),
        .o_x_new (w_x_new),
        .o_delta (w_delta)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_in_hs) w_state_next = StLoad;
            StLoad:  if (w_in_hs && w_idx_last) w_state_next = StCalc;
            StCalc:  if (w_idx_last) w_state_next = StCheck;
            StCheck: w_state_next = (w_done_early || w_done_limit) ? StOut : StCalc;
            StOut:   if (w_out_hs && w_idx_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_iter     <= '0;
            r_iter_max <= '0;
            r_eps      <= '0;
            r_dmax     <= '0;
            r_early    <= 1'b0;
            r_conv     <= 1'b0;
            r_alive    <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_b[k] <= '0;
                r_x[k] <= '0;
            end
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                StIdle: if (w_in_hs) begin
                    r_b[0]     <= i_b_in;
                    r_idx      <= IW'(1);
                    r_iter_max <= i_iter_max;
                    r_eps      <= i_eps;
                    r_early    <= i_early_en;
                    r_conv     <= 1'b0;
                    r_iter     <= '0;
                    for (int k = 0; k < N; k++) r_x[k] <= '0;
                end
                StLoad: if (w_in_hs) begin
                    r_b[r_idx] <= i_b_in;
                    r_idx      <= w_idx_last ? '0 : r_idx + IW'(1);
                end
                StCalc: begin
                    r_x[r_idx] <= w_x_new;
                    r_dmax     <= (r_idx == '0 || w_delta > r_dmax) ? w_delta : r_dmax;
                    r_idx      <= w_idx_last ? '0 : r_idx + IW'(1);
                end
                StCheck: begin
                    r_iter <= w_iter_inc;
                    if (w_done_early) r_conv <= 1'b1;
                end
                StOut: if (w_out_hs) r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
                default: r_idx <= '0;
            endcase
        end
    end

endmodule

// File: doc/gsim_solver.md
# gsim_solver

Parametrised Gauss-Seidel solver for the banded symmetric system with row stencil (1, −6, 13, [20], 13, −6, 1), i.e. 20·x[i] = b[i] + 13(x[i−1]+x[i+1]) − 6(x[i−2]+x[i+2]) + (x[i−3]+x[i+3]). It is the successor to the fixed 16-unknown, fixed-80-iteration solver in the same design. This block generalises system size and fixed-point widths, takes a runtime iteration limit, and adds early exit on convergence. It uses valid/ready handshakes on both sides so it can sit between a stream source and a back-pressuring consumer.

## Interface
Parameters:
- N, 16: number of unknowns; legal range 4..64.
- B_W, 16: width of b samples, signed integer.
- X_W, 32: width of x values, signed fixed-point.
- X_FRAC, 16: fractional bits of x.
- IT_W, 8: width of the iteration counters.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: b_in is valid this cycle.
- in_ready, out, 1: block accepts b_in this cycle.
- b_in, in, B_W: b[k], accepted in order k = 0..N−1.
- iter_max, in, IT_W: sweep limit, sampled on the first b handshake. A value of 0 is treated as 1.
- eps, in, X_W: convergence threshold, unsigned, sampled with iter_max.
- early_en, in, 1: enables early exit, sampled with iter_max.
- out_valid, out, 1: x_out is valid this cycle.
- out_ready, in, 1: consumer accepts x_out this cycle.
- x_out, out, X_W: x[k], presented in order k = 0..N−1.
- out_idx, out, $clog2(N): index k of the current x_out.
- iter_used, out, IT_W: number of sweeps executed; stable while out_valid is high.
- converged, out, 1: the early-exit criterion ended the solve; stable while out_valid is high.
- busy, out, 1: high in every state except IDLE.

## Operation
- State machine: IDLE → LOAD → CALC → CHECK → (CALC | OUT) → IDLE.
- IDLE: in_ready=1. The first in_valid&in_ready handshake stores b[0], samples iter_max/eps/early_en, clears all x to 0, and moves to LOAD.
- LOAD: in_ready=1. Each handshake stores the next b. After b[N−1] is stored, go to CALC with row=0 and iter=0.
- CALC: evaluate one row per cycle using the current x array, updated in place.
  - Row i uses x[i−1], x[i−2] and x[i−3] values already written in this sweep.
  - Neighbours with index outside 0..N−1 contribute 0.
  - After row N−1, go to CHECK.
- Row arithmetic:
  - acc = (sext(b) << X_FRAC) + 13(xl1+xr1) − 6(xl2+xr2) + (xl3+xr3), held at X_W+6 bits, signed.
  - x_new = (acc·13107) >>> 18, an arithmetic shift, i.e. floor.
  - x_new saturates to the signed X_W range.
- Delta tracking: dmax holds the maximum of |x_new − x_old| over the sweep, saturating at all-ones. dmax clears at row 0.
- CHECK (1 cycle): iter += 1.
  - If early_en and dmax ≤ eps: converged=1, go to OUT.
  - Else if iter equals the effective iter_max: converged=0, go to OUT.
  - Otherwise go back to CALC at row 0.
- OUT: out_valid=1, x_out=x[out_idx], starting at out_idx=0.
  - out_idx advances only on out_valid&out_ready.
  - The handshake on index N−1 returns the block to IDLE.
- in_ready=0 in CALC, CHECK and OUT. in_valid is ignored there.

## Timing
- Reset values: in_ready=0 for the cycle of reset, then 1 in IDLE; out_valid=0; x_out=0; out_idx=0; iter_used=0; converged=0; busy=0. All x and b storage cleared.
- Reset asserted mid-operation: the block returns to IDLE immediately and the partial solve is discarded.
- Solve latency: each sweep takes N CALC cycles plus 1 CHECK cycle. out_valid rises (N+1)·iter_used cycles after the cycle following the b[N−1] handshake.
- Output pacing: with out_ready held high, one word per cycle, N cycles total.
- Back-pressure: with out_ready low, x_out and out_idx hold.
- Input gaps: in_valid may drop mid-LOAD. The block waits without timeout.
- Back-to-back solves: in_ready rises in the cycle after the last output handshake.
- Row write: x[i] is registered at the end of its CALC cycle and is visible to row i+1 in the next cycle.

## Structure
- Package gsim_pkg holds:
  - the state enum;
  - the coefficients C1=13, C2=6, C3=1;
  - RECIP=13107 and RSHIFT=18;
  - the saturation helper function.
- Sub-module gsim_row_pe is purely combinational. It takes b, the six neighbour values and x_old, and produces x_new and |delta|.
- The top level contains the FSM, the counters, the b/x register arrays and the dmax register.

## Test plan
- Reset during CALC, with N=16: after rst_n deasserts, busy=0, out_valid=0, in_ready=1. A new load then completes normally.
- Zero system: b all 0, early_en=1, eps=0 → converged=1, iter_used=1, all 16 outputs equal 0.
- Single sweep: b all 20, iter_max=1, early_en=0 → x_out[0]=0x0000FFFF (65535), converged=0, iter_used=1. out_valid rises 17 cycles after load.
- iter_max=0 with early_en=0: behaves exactly like iter_max=1, so iter_used=1.
- Full run: b = 1..16, iter_max=80, early_en=0 → iter_used=80. Outputs match the golden model bit-exactly.
- Early exit and back-pressure:
  - With eps=0x100 and early_en=1, iter_used is below 80 and converged=1.
  - Toggle out_ready at random. x_out and out_idx must hold whenever out_ready=0, and exactly 16 handshakes must occur.
